// File: rtl/regfile_wb_arb_if.sv
// Writeback arbitration bundle: pipeline and multicycle writeback requests,
// multicycle issue tracking, decode hazard checks and the register-file write port.
interface regfile_wb_arb_if;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        p_ready;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        chk_re1;
  logic        chk_re2;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
           iss_valid, iss_addr, chk_re1, chk_re2, chk_addr1, chk_addr2,
    input  p_ready, m_ready, stall, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
           iss_valid, iss_addr, chk_re1, chk_re2, chk_addr1, chk_addr2,
    output p_ready, m_ready, stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: pipeline has priority, the multicycle unit is
// forced through after STARVE_MAX lost cycles; a pending scoreboard drives decode stalls.
module regfile_wb_arb #(
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  regfile_wb_arb_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        p_grant;
  logic        m_grant;
  logic        win_xfer;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        hit1;
  logic        hit2;

  // Grants are suppressed during reset so no handshake can complete then.
  always_comb begin
    p_grant = 1'b0;
    m_grant = 1'b0;
    if (!rst) begin
      if (bus.m_valid && (starve_cnt == STARVE_LIM)) begin
        m_grant = 1'b1;
      end else if (bus.p_valid) begin
        p_grant = 1'b1;
      end else if (bus.m_valid) begin
        m_grant = 1'b1;
      end
    end
  end

  assign bus.p_ready = p_grant;
  assign bus.m_ready = m_grant;

  always_comb begin
    win_addr = 5'd0;
    win_data = 32'd0;
    if (p_grant) begin
      win_addr = bus.p_addr;
      win_data = bus.p_data;
    end else if (m_grant) begin
      win_addr = bus.m_addr;
      win_data = bus.m_data;
    end
    win_xfer = (p_grant || m_grant) && (win_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.m_valid || m_grant) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Clear before set so an issue to the register being written back keeps it pending.
  always_comb begin
    pending_next = pending;
    if (m_grant) begin
      pending_next[bus.m_addr] = 1'b0;
    end
    if (bus.iss_valid) begin
      pending_next[bus.iss_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !win_xfer) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= 5'd0;
      bus.rf_wdata <= 32'd0;
    end else begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= win_addr;
      bus.rf_wdata <= win_data;
    end
  end

  assign hit1      = bus.chk_re1 && (bus.chk_addr1 != 5'd0) && pending[bus.chk_addr1];
  assign hit2      = bus.chk_re2 && (bus.chk_addr2 != 5'd0) && pending[bus.chk_addr2];
  assign bus.stall = !rst && (hit1 || hit2);

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning consecutive lost m-cycles before m is forced a grant (range 1..15).
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 p_valid  in  1  pipeline writeback request.
REQ-005 p_addr  in  5  pipeline destination register.
REQ-006 p_data  in  32  pipeline writeback data.
REQ-007 p_ready  out  1  pipeline request granted this cycle.
REQ-008 m_valid  in  1  multicycle-unit writeback request.
REQ-009 m_addr  in  5  multicycle destination register.
REQ-010 m_data  in  32  multicycle writeback data.
REQ-011 m_ready  out  1  multicycle request granted this cycle.
REQ-012 iss_valid  in  1  multicycle op issued this cycle.
REQ-013 iss_addr  in  5  destination of issued multicycle op.
REQ-014 chk_re1, chk_re2  in  1 each  decode-stage read-port enables.
REQ-015 chk_addr1, chk_addr2  in  5 each  decode-stage read addresses.
REQ-016 stall  out  1  decode must hold: a read hits a pending register.
REQ-017 rf_we  out  1  register-file write enable.
REQ-018 rf_waddr  out  5  register-file write address.
REQ-019 rf_wdata  out  32  register-file write data.

Function
REQ-020 At most one of p_ready/m_ready SHALL be high per cycle; both combinational from valids and starve counter.
REQ-021 Grant order: m if m_valid and starve_cnt==STARVE_MAX; else p if p_valid; else m if m_valid; else none.
REQ-022 Transfer SHALL occur when valid and ready are both high on a requester; no transfer without valid.
REQ-023 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, each cycle m_valid high and m not granted; clear when m granted or m_valid low.
REQ-024 Output stage SHALL be registered: cycle after a transfer, rf_we=1, rf_waddr/rf_wdata = winning addr/data; latency exactly 1 cycle.
REQ-025 Transfer with addr 0 SHALL complete handshake but produce rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-026 Cycle after no transfer: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-027 Scoreboard pending[31:0]: set bit iss_addr on iss_valid when iss_addr!=0; pending[0] SHALL stay 0.
REQ-028 pending[m_addr] SHALL clear on m transfer (visible next cycle, same cycle rf_we rises).
REQ-029 Same-cycle iss_valid and m transfer on same address: set SHALL win (bit stays 1).
REQ-030 iss_valid to already-pending address SHALL leave bit set; no counting.
REQ-031 p transfers SHALL NOT modify pending.
REQ-032 stall = (chk_re1 & chk_addr1!=0 & pending[chk_addr1]) | (chk_re2 & chk_addr2!=0 & pending[chk_addr2]), combinational from registered pending.
REQ-033 Transfer cycle still stalls on that address; following cycle stall drops and regfile same-cycle bypass supplies data.

Reset
REQ-034 While rst high: pending=0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, p_ready=0, m_ready=0.
REQ-035 Reset mid-operation SHALL discard any registered write; first cycle after rst low, rf_we=0.

Verification
REQ-036 p_valid=1,p_addr=5,p_data=0xDEADBEEF alone -> p_ready=1 same cycle; next cycle rf_we=1,rf_waddr=5,rf_wdata=0xDEADBEEF.
REQ-037 p_valid and m_valid held high continuously, STARVE_MAX=4 -> p granted 4 cycles, m granted 5th, counter clears, pattern repeats.
REQ-038 iss_valid,iss_addr=7; then chk_re1=1,chk_addr1=7 -> stall=1 until m transfer to 7; cycle after: stall=0, rf_we=1,rf_waddr=7.
REQ-039 iss_valid iss_addr=0 and m transfer addr 0 -> pending stays 0, stall never asserts, rf_we stays 0.
REQ-040 iss_valid addr 9 same cycle as m transfer addr 9 -> pending[9]=1 next cycle, stall on read of 9 persists.
REQ-041 rst asserted cycle after a transfer with pending[3]=1 -> rf_we=0, pending=0, stall=0 after reset.
